// File: rtl/life_engine_param.sv
// life_engine_param: ROWS x COLS Game of Life engine with step, pause, generation counter and halt detection.
// Build option: define LIFE_TORUS_EN to wrap the grid edges into a torus (default: bounded, dead border).
module life_engine_param #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_seed,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 start,
  input  logic                 run,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic [1:0]           state,
  output logic                 stable
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOADED = 2'b01,
    S_RUN    = 2'b10,
    S_HALT   = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_grid;
  logic [GEN_W-1:0] r_gen_count;
  logic             r_stable;
  logic [N-1:0]     w_next;
  logic             w_stable_next;
  logic             w_gen_sat;
  logic [N-1:0]     w_grid_d;
  logic [GEN_W-1:0] w_gen_d;
  logic             w_stable_d;

  // One Life generation: each cell counts its eight neighbours.
  function automatic logic [N-1:0] f_life_next(input logic [N-1:0] g);
    logic [3:0] n;
    int         rr;
    int         cc;
    int         idx;
    f_life_next = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
`ifdef LIFE_TORUS_EN
            rr = (rr + ROWS) % ROWS;
            cc = (cc + COLS) % COLS;
            idx = rr * COLS + cc;
            if (!(dr == 0 && dc == 0)) n = n + {3'b000, g[idx[IW-1:0]]};
`else
            idx = rr * COLS + cc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
              n = n + {3'b000, g[idx[IW-1:0]]};
`endif
          end
        end
        idx = r * COLS + c;
        f_life_next[idx[IW-1:0]] = (n == 4'd3) | (g[idx[IW-1:0]] & (n == 4'd2));
      end
    end
  endfunction

  assign w_next        = f_life_next(r_grid);
  assign w_stable_next = (w_next == r_grid);
  assign w_gen_sat     = &r_gen_count;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; load_seed outranks start, start outranks step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (load_seed) w_state_nxt = S_LOADED;
                else           w_state_nxt = S_IDLE;
      S_LOADED: if (load_seed)                  w_state_nxt = S_LOADED;
                else if (start)                 w_state_nxt = S_RUN;
                else if (step && w_stable_next) w_state_nxt = S_HALT;
                else                            w_state_nxt = S_LOADED;
      S_RUN:    if (load_seed)          w_state_nxt = S_LOADED;
                else if (!run)          w_state_nxt = S_LOADED;
                else if (w_stable_next) w_state_nxt = S_HALT;
                else if (w_gen_sat)     w_state_nxt = S_HALT;
                else                    w_state_nxt = S_RUN;
      S_HALT:   if (load_seed) w_state_nxt = S_LOADED;
                else           w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values; the counter saturates rather than wrapping.
  always_comb begin
    w_grid_d   = r_grid;
    w_gen_d    = r_gen_count;
    w_stable_d = r_stable;
    if (load_seed) begin
      w_grid_d   = seed;
      w_gen_d    = '0;
      w_stable_d = 1'b0;
    end else begin
      case (r_state)
        S_LOADED: begin
          if (!start && step) begin
            if (w_stable_next) begin
              w_stable_d = 1'b1;
            end else if (!w_gen_sat) begin
              w_grid_d = w_next;
              w_gen_d  = r_gen_count + GEN_W'(1);
            end else begin
              w_grid_d = r_grid;
            end
          end else begin
            w_grid_d = r_grid;
          end
        end
        S_RUN: begin
          if (run && w_stable_next) begin
            w_stable_d = 1'b1;
          end else if (run && !w_gen_sat) begin
            w_grid_d = w_next;
            w_gen_d  = r_gen_count + GEN_W'(1);
          end else begin
            w_grid_d = r_grid;
          end
        end
        default: w_grid_d = r_grid;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grid      <= '0;
      r_gen_count <= '0;
      r_stable    <= 1'b0;
    end else begin
      r_grid      <= w_grid_d;
      r_gen_count <= w_gen_d;
      r_stable    <= w_stable_d;
    end
  end

  assign grid      = r_grid;
  assign gen_count = r_gen_count;
  assign state     = r_state;
  assign stable    = r_stable;

endmodule

// File: doc/life_engine_param.md
Name: life_engine_param

Overview:
Parametrised Conway's Game of Life engine for a ROWS x COLS cell grid. It is the generalised successor of the fixed 8x8 life top. It holds the grid in a register and evolves it one generation per clock under FSM control. It adds single-step, pause/resume, a generation counter, and still-life/saturation halt detection. The seed comes from the upstream seed source (the LFSR block); the grid output drives the display path.

Parameters:
ROWS, 8, grid height in cells (>=3)
COLS, 8, grid width in cells (>=3)
GEN_W, 16, generation counter width (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
load_seed  input  1  load seed into grid (level sampled each clock)
seed  input  ROWS*COLS  initial pattern; bit r*COLS+c = cell (row r, col c)
start  input  1  begin continuous evolution from LOADED
run  input  1  level; 0 while in RUN pauses back to LOADED
step  input  1  advance exactly one generation while in LOADED
grid  output  ROWS*COLS  current generation (registered)
gen_count  output  GEN_W  generations applied since last load
state  output  2  FSM state encoding
stable  output  1  halted because next generation equals current

Behaviour:
- Async reset: grid=0, gen_count=0, state=IDLE, stable=0. Applies mid-run with no residual state.
- Next-state rule, purely combinational from grid:
  - n = count of 8 neighbours (0..8).
  - cell_next = (n==3) | (cell & n==2).
  - Out-of-grid neighbours are dead unless LIFE_TORUS_EN is defined.
- stable_next = (cell_next vector == grid).
- FSM encoding: IDLE=2'b00, LOADED=2'b01, RUN=2'b10, HALT=2'b11.
- Priority within any non-reset cycle: load_seed > start > step; run is evaluated only in RUN.
- IDLE:
  - load_seed -> grid<=seed, gen_count<=0, stable<=0, go LOADED.
  - Other inputs are ignored.
- LOADED:
  - load_seed -> reload as above, stay LOADED.
  - else start -> RUN; no generation is applied on the transition cycle.
  - else step -> grid<=cell_next, gen_count+=1, stay LOADED. A step held high advances once per clock.
  - If step is issued while stable_next=1, the grid is unchanged, gen_count is not incremented, stable<=1, and the FSM goes HALT.
- RUN:
  - load_seed -> reload, go LOADED.
  - else run==0 -> go LOADED; grid and gen_count are held.
  - else stable_next==1 -> stable<=1, go HALT; gen_count not incremented.
  - else gen_count==all-ones -> go HALT, stable stays 0 (saturation); grid not updated.
  - else grid<=cell_next, gen_count+=1.
- HALT:
  - Outputs are held.
  - load_seed -> reload, stable<=0, go LOADED.
  - start and step are ignored.
- Latency: one generation per clock in RUN. grid reflects generation k+1 on the edge after the cycle that applied it.
- An empty grid is a still life: it halts on the first RUN evaluation with stable=1.
- gen_count never wraps.

Optional Feature:
- Macro: LIFE_TORUS_EN.
- Defined: toroidal topology. Row ROWS-1 neighbours row 0 and col COLS-1 neighbours col 0, including the corner diagonals.
- Undefined: cells outside the grid count as dead (bounded plane).
- FSM, counter and halt rules are identical in both builds.

Test Plan:
- Blinker, 8x8, macro off: load seed with row3 cols2-4 set, then step -> grid has row2-4 col3 set, gen_count=1. Second step restores the original pattern, gen_count=2, state=LOADED.
- Block still life: load 2x2 at rows3-4 cols3-4, start, run=1 -> next cycle state=HALT, stable=1, gen_count=0, grid unchanged. Then load_seed -> state=LOADED, stable=0.
- Glider, 8x8, LIFE_TORUS_EN on: load glider, start, run=1; drop run when gen_count==32 -> grid equals the original seed. With the macro off, the same run instead loses the glider at the border, then halts with stable=1.
- Saturation, GEN_W=4: run the blinker -> state=HALT at gen_count=15 with stable=0.
- Pause/priority: in RUN, deassert run -> LOADED with grid held. Assert load_seed and step together -> seed loaded, gen_count=0, no step applied.
- Async reset mid-RUN at gen_count=7 -> grid=0, gen_count=0, state=IDLE, stable=0 immediately. No activity until load_seed.
